// File: rtl/alu_op_sequencer.sv
// Command/response sequencer for a 16-bit combinational ALU; wide (2*DATA_W) ops run as two beats.
// Optional statistics counters are enabled with `define ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_select,
  input  logic                  cmd_mode,
  input  logic                  cmd_wide,
  input  logic                  cmd_chain,
  input  logic                  cmd_carry_in,
  input  logic [2*DATA_W-1:0]   cmd_a,
  input  logic [2*DATA_W-1:0]   cmd_b,
  output logic [3:0]            alu_select,
  output logic                  alu_mode,
  output logic                  alu_carry_in,
  output logic [DATA_W-1:0]     alu_in_a,
  output logic [DATA_W-1:0]     alu_in_b,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_carry_out,
  input  logic                  alu_compare,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_equal,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_wide
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t            state;
  logic              wide_q;
  logic              chain_q;
  logic              cin_q;
  logic [DATA_W-1:0] a_hi_q;
  logic [DATA_W-1:0] b_hi_q;
  logic [DATA_W-1:0] res_lo;
  logic              eq_lo;

  assign cmd_ready = (state == IDLE) & ~rst;

  // Command fields and low-beat results carry no reset; they are only read in states reached after a load.
  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      wide_q  <= cmd_wide;
      chain_q <= cmd_chain;
      cin_q   <= cmd_carry_in;
      a_hi_q  <= cmd_a[2*DATA_W-1:DATA_W];
      b_hi_q  <= cmd_b[2*DATA_W-1:DATA_W];
    end
    if (state == LO) begin
      res_lo <= alu_out;
      eq_lo  <= alu_compare;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_equal    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          alu_in_a <= '0;
          alu_in_b <= '0;
          if (cmd_valid) begin
            alu_select   <= cmd_select;
            alu_mode     <= cmd_mode;
            alu_carry_in <= cmd_carry_in;
            alu_in_a     <= cmd_a[DATA_W-1:0];
            alu_in_b     <= cmd_b[DATA_W-1:0];
            state        <= LO;
          end
        end
        LO: begin
          if (wide_q) begin
            alu_in_a     <= a_hi_q;
            alu_in_b     <= b_hi_q;
            alu_carry_in <= chain_q ? alu_carry_out : cin_q;
            state        <= HI;
          end else begin
            alu_in_a   <= '0;
            alu_in_b   <= '0;
            rsp_valid  <= 1'b1;
            rsp_result <= {{DATA_W{1'b0}}, alu_out};
            rsp_carry  <= alu_carry_out;
            rsp_equal  <= alu_compare;
            state      <= RESP;
          end
        end
        HI: begin
          alu_in_a   <= '0;
          alu_in_b   <= '0;
          rsp_valid  <= 1'b1;
          rsp_result <= {alu_out, res_lo};
          rsp_carry  <= alu_carry_out;
          rsp_equal  <= eq_lo & alu_compare;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_wide <= '0;
    end else if (rsp_valid && rsp_ready) begin
      stat_ops <= sat_inc(stat_ops);
      if (wide_q) stat_wide <= sat_inc(stat_wide);
    end
  end
`else
  assign stat_ops  = '0;
  assign stat_wide = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a behavioural ALU model on the alu_* port.
module tb_alu_op_sequencer;
  localparam int DATA_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_select = '0;
  logic        cmd_mode = 1'b0;
  logic        cmd_wide = 1'b0;
  logic        cmd_chain = 1'b0;
  logic        cmd_carry_in = 1'b0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_carry_in;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [15:0] alu_out;
  logic        alu_carry_out;
  logic        alu_compare;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_equal;
  logic [15:0] stat_ops;
  logic [15:0] stat_wide;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        eq;
    logic        wide;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int exp_ops = 0;
  int exp_wide = 0;

  alu_op_sequencer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_select(cmd_select), .cmd_mode(cmd_mode), .cmd_wide(cmd_wide),
    .cmd_chain(cmd_chain), .cmd_carry_in(cmd_carry_in),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_select(alu_select), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_equal(rsp_equal),
    .stat_ops(stat_ops), .stat_wide(stat_wide)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: add with carry (select 9, arithmetic) and AND (select 11, logic).
  always_comb begin
    alu_out       = '0;
    alu_carry_out = 1'b0;
    if (alu_select == 4'b1001 && !alu_mode)
      {alu_carry_out, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_carry_in};
    else if (alu_select == 4'b1011 && alu_mode)
      alu_out = alu_in_a & alu_in_b;
    alu_compare = (alu_in_a == alu_in_b);
  end

  function automatic logic [31:0] st(input int v);
`ifdef ALU_SEQ_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] sel, input logic mode, input logic wide,
                       input logic chain, input logic cin, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ec,
                       input logic eq);
    int n = 0;
    cmd_select = sel; cmd_mode = mode; cmd_wide = wide; cmd_chain = chain;
    cmd_carry_in = cin; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin step(); n++; end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    step();
    acc_cyc = cyc - 1;
    cmd_valid = 1'b0;
    // Scramble the command bus to prove the sequencer latched it.
    cmd_a = $urandom; cmd_b = $urandom; cmd_chain = ~chain; cmd_carry_in = ~cin;
    cmd_wide = ~wide;
    sb.push_back('{res: er, c: ec, eq: eq, wide: wide});
  endtask

  task automatic wait_rsp(input int exp_lat);
    int n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      last = sb.pop_front();
      chk("result", rsp_result, last.res);
      chk("carry", {31'd0, rsp_carry}, {31'd0, last.c});
      chk("equal", {31'd0, rsp_equal}, {31'd0, last.eq});
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_ops++;
    if (last.wide) exp_wide++;
    chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("alu_a_clear", {16'd0, alu_in_a}, 32'd0);
    chk("stat_ops", {16'd0, stat_ops}, st(exp_ops));
    chk("stat_wide", {16'd0, stat_wide}, st(exp_wide));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step(); step();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_alu_a", {16'd0, alu_in_a}, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_select}, 32'd0);
    chk("rst_stat_ops", {16'd0, stat_ops}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Narrow add
    issue(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0);
    chk("n_lo_a", {16'd0, alu_in_a}, 32'h3);
    chk("n_lo_b", {16'd0, alu_in_b}, 32'h4);
    chk("n_busy", {31'd0, cmd_ready}, 32'd0);
    wait_rsp(2);
    handshake();

    // Narrow overflow; upper operand bits and chain must be ignored
    issue(4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD_FFFF, 32'h1234_0001, 32'h0000_0000, 1'b1, 1'b0);
    wait_rsp(2);
    handshake();

    // Wide chained add
    issue(4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0001_FFFF, 32'h0000_0001, 32'h0002_0000, 1'b0, 1'b0);
    chk("wc_lo_a", {16'd0, alu_in_a}, 32'hFFFF);
    chk("wc_lo_b", {16'd0, alu_in_b}, 32'h0001);
    chk("wc_lo_cin", {31'd0, alu_carry_in}, 32'd0);
    step();
    chk("wc_hi_a", {16'd0, alu_in_a}, 32'h0001);
    chk("wc_hi_b", {16'd0, alu_in_b}, 32'h0000);
    chk("wc_hi_cin", {31'd0, alu_carry_in}, 32'd1);
    wait_rsp(3);
    handshake();

    // Wide unchained add
    issue(4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0);
    step();
    chk("wu_hi_cin", {31'd0, alu_carry_in}, 32'd0);
    wait_rsp(3);
    handshake();

    // Backpressure with a second command waiting
    issue(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
    wait_rsp(2);
    cmd_select = 4'd11; cmd_mode = 1'b1; cmd_wide = 1'b0; cmd_chain = 1'b0;
    cmd_carry_in = 1'b0; cmd_a = 32'h55; cmd_b = 32'h55; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'h0000_F000);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    handshake();
    chk("bp_ready_after", {31'd0, cmd_ready}, 32'd1);
    issue(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h55, 32'h55, 1'b0, 1'b1);
    wait_rsp(2);
    handshake();

    // Wide equality
    issue(4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h2468_ACF0, 1'b0, 1'b1);
    wait_rsp(3);
    handshake();

    // Reset while in HI drops the command
    issue(4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
    step();
    chk("pre_rst_stat", {16'd0, stat_ops}, st(exp_ops));
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    exp_ops = 0;
    exp_wide = 0;
    chk("hr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hr_alu_a", {16'd0, alu_in_a}, 32'd0);
    chk("hr_alu_cin", {31'd0, alu_carry_in}, 32'd0);
    chk("hr_stat_ops", {16'd0, stat_ops}, 32'd0);
    #1;
    chk("hr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Post-reset command
    issue(4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0020, 32'h0000_0031, 1'b0, 1'b0);
    wait_rsp(2);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
